rom_serial_streamer: RTL and testbench
======================================

// Module: rom_serial_streamer
// PURPOSE
//  Parametrised successor to the ROM management block. On each tick it fetches the next
//  ROM word at an auto-incrementing, wrapping address and loads it into a shift register.
//  It then streams the word out on SO, one bit per clock, with a valid strobe.
//  It sits between the ROM/sine-table and the serial DAC/link front end.
// PARAMETERS
//  DATA_W    32   ROM word width = bits shifted per word (2..64)
//  ADDR_W    8    ROM address width
//  DEPTH     256  words used; address wraps DEPTH-1 -> 0 (DEPTH <= 2**ADDR_W)
//  ROM_LAT   1    cycles from rom_en high to Data_bus valid (1..4)
//  MSB_FIRST 1    1: shift bit DATA_W-1 first; 0: shift bit 0 first
// PORTS
//  clk          in   1       system clock, rising edge
//  RST_n        in   1       asynchronous reset, active low
//  tick         in   1       start request, sampled each clk
//  clr_overrun  in   1       synchronous clear of overrun
//  Data_bus     in   DATA_W  ROM read data
//  rom_addr     out  ADDR_W  ROM address
//  rom_en       out  1       ROM read enable
//  load         out  1       1-cycle pulse: Data_bus captured into shift register
//  pdata        out  DATA_W  parallel copy of the word currently being shifted
//  SO           out  1       serial data out
//  so_valid     out  1       SO carries a valid bit
//  word_done    out  1       1-cycle pulse on the last bit of a word
//  busy         out  1       state != IDLE
//  overrun      out  1       sticky: tick arrived while a pending tick was already queued
// BEHAVIOUR
//  Reset (RST_n=0, async, any state): state=IDLE; rom_addr=0; pdata=0; shift reg=0;
//   bit counter=0; pending=0. All outputs 0.
//  FSM: IDLE -> FETCH -> LOAD -> SHIFT -> (FETCH if pending else IDLE).
//  IDLE: tick=1 -> FETCH next cycle.
//  FETCH: rom_en=1, rom_addr held. Lasts exactly ROM_LAT cycles, then -> LOAD.
//  LOAD (1 cycle): shift reg <= Data_bus; pdata <= Data_bus; load=1; -> SHIFT.
//  SHIFT (exactly DATA_W cycles): so_valid=1.
//   SO = shift reg [DATA_W-1] (MSB_FIRST=1) or [0] (MSB_FIRST=0); register shifts after each bit.
//   Last cycle: word_done=1; rom_addr <= (rom_addr==DEPTH-1) ? 0 : rom_addr+1.
//  Latency: tick seen in cycle t -> load in cycle t+1+ROM_LAT; first valid SO in t+2+ROM_LAT.
//  Back-to-back: pending set by tick in FETCH/LOAD/SHIFT.
//   On the last SHIFT cycle, pending=1 -> FETCH next cycle, pending cleared.
//   The gap between words is ROM_LAT+1 cycles with so_valid=0.
//  tick in the same cycle as the last SHIFT bit counts as pending (queued, not dropped).
//  Overrun: tick while pending=1 and not consumed that cycle -> overrun<=1 (extra tick dropped).
//   clr_overrun=1 -> overrun<=0; clr has priority over a simultaneous set.
//  Held tick: each high cycle is a request; one tick per word is expected.
//  Outside SHIFT: SO=0, so_valid=0. Outside FETCH: rom_en=0. pdata holds until next LOAD.
//  Counter width: $clog2(DATA_W+1). No combinational path from inputs to outputs.
// TESTING
//  1 Reset: RST_n=0 mid-SHIFT -> all outputs 0 immediately, without a clk edge.
//    Release, tick -> rom_addr=0 fetched.
//  2 Single word, DATA_W=32, MSB_FIRST=1, Data_bus=32'hA5F0_0F5A:
//    SO over 32 valid cycles = 1010_0101..., word_done on the 32nd bit, rom_addr 0->1.
//  3 MSB_FIRST=0, Data_bus=32'h0000_0001, ROM_LAT=2:
//    load 3 cycles after tick; first SO=1, then 31 zeros.
//  4 Wrap: DEPTH=4, 5 ticks -> addresses fetched 0,1,2,3,0.
//  5 Back-to-back: tick during SHIFT -> next FETCH right after word_done, gap of ROM_LAT+1 cycles.
//    Two ticks during SHIFT -> overrun=1; clr_overrun -> 0.
//  6 Tick coincident with the last SHIFT bit -> word queued; random Data_bus compared against
//    serial reassembly over 100 words.

Source files
------------

// File: rtl/rom_serial_streamer.sv
// Fetches ROM words at a wrapping auto-incrementing address on each tick and streams
// them out serially with a valid strobe; extra ticks are queued once, further ones flagged.
module rom_serial_streamer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int ROM_LAT   = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              RST_n,
  input  logic              tick,
  input  logic              clr_overrun,
  input  logic [DATA_W-1:0] Data_bus,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  output logic              load,
  output logic [DATA_W-1:0] pdata,
  output logic              SO,
  output logic              so_valid,
  output logic              word_done,
  output logic              busy,
  output logic              overrun
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int LAT_W  = $clog2(ROM_LAT + 1);
  localparam int SO_IDX = (MSB_FIRST != 0) ? DATA_W - 1 : 0;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SHIFT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              pending;
  logic              last_bit;
  logic              fetch_done;

  assign last_bit   = (state == SHIFT) && (bit_cnt == CNT_W'(DATA_W - 1));
  assign fetch_done = (state == FETCH) && (lat_cnt == LAT_W'(ROM_LAT - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaulting state_nxt first keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (tick) state_nxt = FETCH;
      FETCH: if (fetch_done) state_nxt = LOAD;
      LOAD:  state_nxt = SHIFT;
      SHIFT: if (last_bit) state_nxt = (pending || tick) ? FETCH : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs decode registered state only, so no input reaches an output combinationally.
  always_comb begin
    rom_en    = (state == FETCH);
    load      = (state == LOAD);
    so_valid  = (state == SHIFT);
    busy      = (state != IDLE);
    word_done = last_bit;
    SO        = (state == SHIFT) && shreg[SO_IDX];
  end

  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      rom_addr <= '0;
      pdata    <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      lat_cnt  <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      lat_cnt <= (state == FETCH) ? lat_cnt + LAT_W'(1) : '0;

      if (state == LOAD) begin
        shreg   <= Data_bus;
        pdata   <= Data_bus;
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        shreg   <= (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
        bit_cnt <= bit_cnt + CNT_W'(1);
      end

      if (last_bit)
        rom_addr <= (rom_addr == ADDR_W'(DEPTH - 1)) ? '0 : rom_addr + ADDR_W'(1);

      // The last bit consumes a queued request; a tick in that same cycle re-queues one.
      if (last_bit)
        pending <= pending & tick;
      else if (tick && state != IDLE)
        pending <= 1'b1;

      if (clr_overrun)
        overrun <= 1'b0;
      else if (tick && pending && !last_bit)
        overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_serial_streamer.sv
// Scoreboard bench: two streamer instances (MSB-first/ROM_LAT=1/DEPTH=4 and
// LSB-first/ROM_LAT=2/DEPTH=256) fed by latency-accurate ROM models.
module tb_rom_serial_streamer;

  localparam logic [31:0] GARB = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // instance a: MSB first, ROM_LAT=1, DEPTH=4
  logic        tick_a, clr_a;
  logic [31:0] data_a, pdata_a, pipe_a;
  logic [7:0]  rom_addr_a;
  logic        rom_en_a, load_a, so_a, so_valid_a, word_done_a, busy_a, overrun_a;
  // instance b: LSB first, ROM_LAT=2, DEPTH=256
  logic        tick_b, clr_b;
  logic [31:0] data_b, pdata_b, pipe_b0, pipe_b1;
  logic [7:0]  rom_addr_b;
  logic        rom_en_b, load_b, so_b, so_valid_b, word_done_b, busy_b, overrun_b;

  logic [31:0] rom_a [256];
  logic [31:0] rom_b [256];
  logic [31:0] exp_q_a [$];
  logic [31:0] exp_q_b [$];
  logic [31:0] acc_a, acc_b;
  int          nb_a, nb_b;
  logic [7:0]  exp_addr_b;

  always #5 clk = ~clk;

  rom_serial_streamer #(.DATA_W(32), .ADDR_W(8), .DEPTH(4), .ROM_LAT(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .RST_n(rst_n), .tick(tick_a), .clr_overrun(clr_a), .Data_bus(data_a),
    .rom_addr(rom_addr_a), .rom_en(rom_en_a), .load(load_a), .pdata(pdata_a), .SO(so_a),
    .so_valid(so_valid_a), .word_done(word_done_a), .busy(busy_a), .overrun(overrun_a));

  rom_serial_streamer #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .ROM_LAT(2), .MSB_FIRST(0)) dut_b (
    .clk(clk), .RST_n(rst_n), .tick(tick_b), .clr_overrun(clr_b), .Data_bus(data_b),
    .rom_addr(rom_addr_b), .rom_en(rom_en_b), .load(load_b), .pdata(pdata_b), .SO(so_b),
    .so_valid(so_valid_b), .word_done(word_done_b), .busy(busy_b), .overrun(overrun_b));

  // ROM models: data is only valid exactly ROM_LAT cycles into an enable burst.
  always @(posedge clk) begin
    pipe_a  <= rom_en_a ? rom_a[rom_addr_a] : GARB;
    pipe_b0 <= rom_en_b ? rom_b[rom_addr_b] : GARB;
    pipe_b1 <= rom_en_b ? pipe_b0 : GARB;
  end
  assign data_a = pipe_a;
  assign data_b = pipe_b1;

  // Serial reassembly and scoreboard compare
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_a = '0; nb_a = 0;
    end else begin
      if (so_valid_a) begin acc_a = {acc_a[30:0], so_a}; nb_a++; end
      if (word_done_a) begin
        checks++;
        if (exp_q_a.size() == 0) begin
          errors++; $display("FAIL word_a: got unexpected word %h, required none", acc_a);
        end else begin
          logic [31:0] e;
          e = exp_q_a.pop_front();
          if (acc_a !== e || pdata_a !== e || nb_a != 32) begin
            errors++;
            $display("FAIL word_a: serial %h pdata %h bits %0d, required %h with 32 bits", acc_a, pdata_a, nb_a, e);
          end
        end
        acc_a = '0; nb_a = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      acc_b = '0; nb_b = 0;
    end else begin
      if (so_valid_b) begin acc_b = {so_b, acc_b[31:1]}; nb_b++; end
      if (word_done_b) begin
        checks++;
        if (exp_q_b.size() == 0) begin
          errors++; $display("FAIL word_b: got unexpected word %h, required none", acc_b);
        end else begin
          logic [31:0] e;
          e = exp_q_b.pop_front();
          if (acc_b !== e || pdata_b !== e || nb_b != 32) begin
            errors++;
            $display("FAIL word_b: serial %h pdata %h bits %0d, required %h with 32 bits", acc_b, pdata_b, nb_b, e);
          end
        end
        acc_b = '0; nb_b = 0;
      end
    end
  end

  // Bounded wait: returns on the first later negedge where the selected event holds.
  task automatic wait_for(input int sel, input int limit, input string name);
    int  n = 0;
    bit  hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (sel)
        0: hit = load_a;
        1: hit = word_done_a;
        2: hit = !busy_a;
        3: hit = load_b;
        4: hit = word_done_b;
        default: hit = !busy_b;
      endcase
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: event not seen within %0d cycles, required it", name, limit);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    exp_q_a.delete(); exp_q_b.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [75:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {rom_addr_a, rom_en_a, load_a, pdata_a, so_a, so_valid_a, word_done_a, busy_a, overrun_a};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_a: outputs %h, required 0", outs); end
    outs = {rom_addr_b, rom_en_b, load_b, pdata_b, so_b, so_valid_b, word_done_b, busy_b, overrun_b};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_b: outputs %h, required 0", outs); end
    rst_n = 1'b1;
    @(negedge clk);
    tick_a = 1'b1; exp_q_a.push_back(rom_a[0]);
    @(negedge clk);
    tick_a = 1'b0;
    checks++;
    if (rom_en_a !== 1'b1 || rom_addr_a !== 8'd0) begin
      errors++; $display("FAIL reset_fetch: rom_en %b addr %0d, required 1 and 0", rom_en_a, rom_addr_a);
    end
    wait_for(0, 10, "reset_load");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    outs = {rom_addr_a, rom_en_a, load_a, pdata_a, so_a, so_valid_a, word_done_a, busy_a, overrun_a};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_async: outputs %h, required 0", outs); end
    exp_q_a.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_word();
    @(negedge clk);
    tick_a = 1'b1; exp_q_a.push_back(rom_a[0]);
    @(negedge clk);
    tick_a = 1'b0;
    checks++;
    if (rom_en_a !== 1'b1 || load_a !== 1'b0) begin
      errors++; $display("FAIL single_fetch: rom_en %b load %b, required 1 0", rom_en_a, load_a);
    end
    @(negedge clk);
    checks++;
    if (load_a !== 1'b1) begin errors++; $display("FAIL single_load: load %b, required 1", load_a); end
    @(negedge clk);
    checks++;
    if (so_valid_a !== 1'b1 || so_a !== 1'b1 || pdata_a !== 32'hA5F0_0F5A) begin
      errors++;
      $display("FAIL single_first: valid %b so %b pdata %h, required 1 1 a5f00f5a", so_valid_a, so_a, pdata_a);
    end
    wait_for(1, 40, "single_done");
    @(negedge clk);
    checks++;
    if (rom_addr_a !== 8'd1 || busy_a !== 1'b0 || so_valid_a !== 1'b0 || so_a !== 1'b0) begin
      errors++;
      $display("FAIL single_after: addr %0d busy %b valid %b so %b, required 1 0 0 0", rom_addr_a, busy_a, so_valid_a, so_a);
    end
  endtask

  task automatic test_lsb_first();
    @(negedge clk);
    tick_b = 1'b1; exp_q_b.push_back(rom_b[0]);
    @(negedge clk);
    tick_b = 1'b0;
    @(negedge clk);
    checks++;
    if (rom_en_b !== 1'b1 || load_b !== 1'b0) begin
      errors++; $display("FAIL lsb_fetch2: rom_en %b load %b, required 1 0", rom_en_b, load_b);
    end
    @(negedge clk);
    checks++;
    if (load_b !== 1'b1) begin errors++; $display("FAIL lsb_load: load %b, required 1", load_b); end
    @(negedge clk);
    checks++;
    if (so_valid_b !== 1'b1 || so_b !== 1'b1) begin
      errors++; $display("FAIL lsb_first_bit: valid %b so %b, required 1 1", so_valid_b, so_b);
    end
    wait_for(4, 40, "lsb_done");
    @(negedge clk);
    checks++;
    if (rom_addr_b !== 8'd1) begin errors++; $display("FAIL lsb_addr: addr %0d, required 1", rom_addr_b); end
  endtask

  task automatic test_wrap();
    apply_reset();
    exp_addr_b = 8'd0;
    for (int i = 0; i < 5; i++) begin
      logic [7:0] ea;
      ea = 8'(i % 4);
      tick_a = 1'b1; exp_q_a.push_back(rom_a[ea]);
      @(negedge clk);
      tick_a = 1'b0;
      wait_for(0, 10, "wrap_load");
      checks++;
      if (rom_addr_a !== ea) begin
        errors++; $display("FAIL wrap_addr: word %0d addr %0d, required %0d", i, rom_addr_a, ea);
      end
      wait_for(1, 40, "wrap_done");
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int gap;
    tick_a = 1'b1; exp_q_a.push_back(rom_a[1]);
    @(negedge clk);
    tick_a = 1'b0;
    wait_for(0, 10, "b2b_load");
    repeat (3) @(negedge clk);
    tick_a = 1'b1; exp_q_a.push_back(rom_a[2]);
    @(negedge clk);
    tick_a = 1'b0;
    wait_for(1, 40, "b2b_done1");
    gap = 0;
    @(negedge clk);
    checks++;
    if (rom_en_a !== 1'b1) begin errors++; $display("FAIL b2b_refetch: rom_en %b, required 1", rom_en_a); end
    while (!so_valid_a && gap < 20) begin gap++; @(negedge clk); end
    checks++;
    if (gap != 2) begin errors++; $display("FAIL b2b_gap: gap %0d cycles, required 2", gap); end
    // now in the first SHIFT cycle of the second word
    tick_a = 1'b1; exp_q_a.push_back(rom_a[3]);
    @(negedge clk);
    @(negedge clk);
    tick_a = 1'b0;
    checks++;
    if (overrun_a !== 1'b1) begin errors++; $display("FAIL overrun_set: overrun %b, required 1", overrun_a); end
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL overrun_clr: overrun %b, required 0", overrun_a); end
    tick_a = 1'b1; clr_a = 1'b1;
    @(negedge clk);
    tick_a = 1'b0; clr_a = 1'b0;
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL overrun_prio: overrun %b, required 0", overrun_a); end
    wait_for(1, 40, "b2b_done2");
    wait_for(1, 40, "b2b_done3");
    wait_for(2, 10, "b2b_idle");
    checks++;
    if (rom_addr_a !== 8'd0) begin errors++; $display("FAIL b2b_addr: addr %0d, required 0", rom_addr_a); end
  endtask

  task automatic test_coincident();
    tick_b = 1'b1; exp_q_b.push_back(rom_b[exp_addr_b]); exp_addr_b++;
    @(negedge clk);
    tick_b = 1'b0;
    for (int i = 1; i < 100; i++) begin
      wait_for(4, 60, "coin_done");
      tick_b = 1'b1; exp_q_b.push_back(rom_b[exp_addr_b]); exp_addr_b++;
      @(negedge clk);
      tick_b = 1'b0;
      checks++;
      if (rom_en_b !== 1'b1 || busy_b !== 1'b1) begin
        errors++; $display("FAIL coin_queue: word %0d rom_en %b busy %b, required 1 1", i, rom_en_b, busy_b);
      end
    end
    wait_for(4, 60, "coin_last");
    wait_for(5, 10, "coin_idle");
    checks++;
    if (rom_addr_b !== exp_addr_b || overrun_b !== 1'b0) begin
      errors++; $display("FAIL coin_end: addr %0d overrun %b, required %0d 0", rom_addr_b, overrun_b, exp_addr_b);
    end
  endtask

  initial begin
    tick_a = 1'b0; clr_a = 1'b0; tick_b = 1'b0; clr_b = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      rom_a[i] = $urandom;
      rom_b[i] = $urandom;
    end
    rom_a[0] = 32'hA5F0_0F5A;
    rom_a[1] = 32'h1234_5678;
    rom_a[2] = 32'h9ABC_DEF0;
    rom_a[3] = 32'h0F0F_3C3C;
    rom_b[0] = 32'h0000_0001;

    test_reset();
    test_single_word();
    test_lsb_first();
    test_wrap();
    test_back_to_back();
    test_coincident();

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: left %0d/%0d words, required 0/0", exp_q_a.size(), exp_q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
